// File: rtl/task1.sv
// rtl/task1.sv - registered 4-bit binary to two-digit packed BCD converter
module task1 (
  input  logic       D,
  input  logic       C,
  input  logic       B,
  input  logic       A,
  output logic [7:0] BCD,
  input  logic       clk,
  input  logic       reset
);

  logic [3:0] n;
  logic [3:0] tens;
  logic [3:0] units;

  // A nibble tops out at 15, so the tens digit is only ever 0 or 1.
  always_comb begin
    n     = {A, B, C, D};
    tens  = 4'd0;
    units = n;
    if (n >= 4'd10) begin
      tens  = 4'd1;
      units = n - 4'd10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BCD <= 8'h00;
    end else begin
      BCD <= {tens, units};
    end
  end

endmodule

// File: tb/tb_task1.sv
// tb/tb_task1.sv - directed and random checks of task1 against an arithmetic BCD model
module tb_task1;

  logic       clk = 1'b0;
  logic       reset;
  logic       A, B, C, D;
  logic [7:0] BCD;

  int vectors = 0;
  int errors  = 0;

  task1 dut (
    .D     (D),
    .C     (C),
    .B     (B),
    .A     (A),
    .BCD   (BCD),
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n);
    logic [3:0] v;
    v = 4'(n);
    {A, B, C, D} = v;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input string tag, input int n);
    drive(n);
    @(posedge clk);
    #1;
    check(tag, BCD, ref_bcd(n));
    check({tag, "_hi"}, {5'd0, BCD[7:5]}, 8'h00);
    check({tag, "_unit_le9"}, {7'd0, BCD[3:0] <= 4'd9}, 8'h01);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    {A, B, C, D} = 4'b1111;
    #2 reset = 1'b1;
    #1 check("reset_async", BCD, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", BCD, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 16; n++) apply("sweep", n);

    apply("b9", 9);
    drive(10);
    #1 check("b10_before_edge", BCD, 8'h09);
    @(posedge clk);
    #1 check("b10_after_edge", BCD, 8'h10);
    check("b10_tens_bit", {7'd0, BCD[4]}, 8'h01);
    @(negedge clk);

    apply("hold3", 3);
    drive(12);
    #1 check("hold_between_edges", BCD, 8'h03);
    @(posedge clk);
    #1 check("hold_next_edge", BCD, 8'h12);
    @(negedge clk);

    apply("pre_reset15", 15);
    #2 reset = 1'b1;
    #1 check("midrun_reset", BCD, 8'h00);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("midrun_restore", BCD, 8'h15);
    @(negedge clk);

    {A, B, C, D} = 4'b1000;
    @(posedge clk);
    #1 check("order_a_msb", BCD, 8'h08);
    @(negedge clk);
    {A, B, C, D} = 4'b0001;
    @(posedge clk);
    #1 check("order_d_lsb", BCD, 8'h01);
    @(negedge clk);

    for (int i = 0; i < 64; i++) apply("random", int'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
